spsram_bist: RTL and testbench
==============================

# spsram_bist

Built-in self-test controller for the 64x64 single-port SRAM (`spsram_extension`). It drives the SRAM command interface as the initiator, playing the same role the bench plays. On start it runs a two-pass walking-one / walking-zero write-then-read sequence over every address, compares each read word against the expected pattern, and reports pass/fail, an error count and the first failing address. It sits between the SoC test-control register and the SRAM macro, muxed in front of the functional port.

## Interface
- `DW`, 64, SRAM word width; must be a power of two.
- `AW`, 6, SRAM address width; DEPTH = 2^AW.
- `ERR_W`, 8, error counter width.
- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_rstn`  in  1  reset, synchronous and active-low.
- `i_start`  in  1  start request; sampled only in IDLE.
- `o_busy`  out  1  test in progress.
- `o_done`  out  1  one-cycle pulse when the test completes.
- `o_pass`  out  1  result: 1 = zero mismatches; held until the next start.
- `o_err_cnt`  out  ERR_W  mismatch count; saturating; held until the next start.
- `o_err_addr`  out  AW  address of the first mismatch; 0 if none.
- `o_mem_data`  out  DW  SRAM write data (to `i_data`).
- `o_mem_addr`  out  AW  SRAM address (to `i_addr`).
- `o_mem_wen`  out  1  SRAM write enable, 1 = write (to `i_wen`).
- `o_mem_cen`  out  1  SRAM chip enable, 1 = active (to `i_cen`).
- `o_mem_oen`  out  1  SRAM output enable, 1 = read (to `i_oen`).
- `i_mem_data`  in  DW  SRAM read data (from `o_data`); valid one cycle after a read is sampled.

## Operation
- States: IDLE, WR0, RD0, WR1, RD1, DRAIN, DONE.
  - IDLE -> WR0 on `i_start`=1.
  - Each of WR0/RD0/WR1/RD1 runs DEPTH cycles, with the address counter going 0..DEPTH-1. On the last address the counter wraps to 0 and the state advances: WR0 -> RD0 -> WR1 -> RD1 -> DRAIN.
  - DRAIN -> DONE -> IDLE, one cycle each.
- Pattern P(a) = 1 << (a mod DW), where the index is the low log2(DW) bits of a, zero-extended.
  - Pass 0 (WR0/RD0) uses P(a).
  - Pass 1 (WR1/RD1) uses ~P(a).
- SRAM command outputs are combinational from state and address counter:
  - WR: cen=1, wen=1, oen=0, data=pattern.
  - RD: cen=1, wen=0, oen=1, data=0.
  - All other states: cen=wen=oen=0, addr=0, data=0.
- Compare pipeline: each RD cycle registers {valid, addr, expected}. On the following edge, `i_mem_data` is compared against expected. The last RD0 compare therefore lands in the first WR1 cycle, and the last RD1 compare lands in DRAIN.
- On a mismatch:
  - `o_err_cnt` increments, saturating at 2^ERR_W-1.
  - If the count was 0 before this mismatch, `o_err_addr` latches the address.
- On the start edge: `o_err_cnt`, `o_err_addr`, `o_pass` and the compare valid bit are cleared.
- `o_pass` is set in DONE when `o_err_cnt`==0.
- `i_start` while not in IDLE (including DONE) is ignored.
- Reset mid-test: the next edge forces IDLE, and every output returns to its reset value. No partial command is completed.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- Start edge E0 (`i_start` sampled in IDLE):
  - The first write (addr 0, data 1) is presented during the cycle after E0.
  - `o_busy`=1 from E0 until the edge leaving DRAIN.
- Phase boundaries:
  - WR0 covers E0..E(DEPTH).
  - RD0 ends at E(2*DEPTH).
  - WR1 ends at E(3*DEPTH).
  - RD1 ends at E(4*DEPTH).
  - The final compare occurs at E(4*DEPTH+1).
- `o_done`=1 for exactly the cycle after E(4*DEPTH+1); `o_pass` is valid in the same cycle. DEPTH=64 gives 257 edges from start to done.
- Read latency assumed from the SRAM: exactly 1 cycle. There is no back-pressure.
- `o_busy` and `o_done` are never high together.

## Test plan
- **Ideal 64x64 model, start pulse:**
  - Writes: addr0=0x1 through addr63=0x8000_0000_0000_0000, then the inverted patterns.
  - `o_done` pulses 257 edges after start.
  - `o_pass`=1, `o_err_cnt`=0, `o_err_addr`=0.
- **Model with addr 5 bit 5 stuck-at-0:**
  - Only the pass-0 read of addr 5 fails.
  - `o_err_cnt`=1, `o_err_addr`=5, `o_pass`=0.
- **Model with data bit 0 stuck-at-0 at all addresses:**
  - Pass 0 fails at addr 0; pass 1 fails at addr 1..63.
  - `o_err_cnt`=64, `o_err_addr`=0.
- **Model always returning 0, ERR_W=6:**
  - 128 mismatches saturate the counter.
  - `o_err_cnt`=63, `o_err_addr`=0.
- **Start handling:**
  - Re-assert `i_start` at cycles 10 and 257 (DONE): both ignored, `o_done` pulses once.
  - A start after DONE reruns the test and clears the prior error results, with identical timing.
- **Reset mid-operation:**
  - Drive `i_rstn`=0 for one edge at cycle 100 (in RD0).
  - Next cycle: `o_busy`=0, `o_mem_cen`=0, all results 0.
  - A subsequent start completes normally with `o_pass`=1.

Source files
------------

// File: rtl/spsram_bist.sv
// spsram_bist - built-in self-test controller for the single-port SRAM.
//
// Runs a walking-one pass (write all, read all) followed by a walking-zero
// pass over every address. Each read word is compared one cycle later
// against the pattern that was written. The controller reports pass/fail,
// a saturating mismatch count and the address of the first mismatch.
//
// Ports
//   i_clk, i_rstn        clock, synchronous active-low reset
//   i_start              start request, only honoured in IDLE
//   o_busy, o_done       test running / one-cycle completion pulse
//   o_pass, o_err_cnt,   results, held until the next start
//   o_err_addr
//   o_mem_*              SRAM command port (combinational from state/counter)
//   i_mem_data           SRAM read data, valid the cycle after a read
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for i_start, SRAM port quiet
// WR0   | write P(a) to every address
// RD0   | read every address, expect P(a)
// WR1   | write ~P(a) to every address
// RD1   | read every address, expect ~P(a)
// DRAIN | last read compare in flight
// DONE  | o_done pulse, results final
module spsram_bist #(
  parameter int DW    = 64,
  parameter int AW    = 6,
  parameter int ERR_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [AW-1:0]    o_err_addr,
  output logic [DW-1:0]    o_mem_data,
  output logic [AW-1:0]    o_mem_addr,
  output logic             o_mem_wen,
  output logic             o_mem_cen,
  output logic             o_mem_oen,
  input  logic [DW-1:0]    i_mem_data
);

  localparam int LW = $clog2(DW);
  // Bits of the address that select the walking bit; the whole counter
  // when the array is shallower than the word is wide.
  localparam int IW = (AW < LW) ? AW : LW;

  typedef enum logic [2:0] {
    IDLE, WR0, RD0, WR1, RD1, DRAIN, DONE
  } state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic             cmp_valid;
  logic [AW-1:0]    cmp_addr;
  logic [DW-1:0]    cmp_exp;

  logic [DW-1:0]    pat;
  logic [DW-1:0]    rd_exp;
  logic             rd_phase;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  always_comb begin
    pat        = {{(DW-1){1'b0}}, 1'b1} << cnt[IW-1:0];
    rd_exp     = (state == RD1) ? ~pat : pat;
    rd_phase   = (state == RD0) || (state == RD1);
    o_mem_data = '0;
    o_mem_addr = '0;
    o_mem_wen  = 1'b0;
    o_mem_cen  = 1'b0;
    o_mem_oen  = 1'b0;
    case (state)
      WR0, WR1: begin
        o_mem_cen  = 1'b1;
        o_mem_wen  = 1'b1;
        o_mem_addr = cnt;
        o_mem_data = (state == WR1) ? ~pat : pat;
      end
      RD0, RD1: begin
        o_mem_cen  = 1'b1;
        o_mem_oen  = 1'b1;
        o_mem_addr = cnt;
      end
      default: ;
    endcase
  end

  // The count seen by o_pass must include the compare landing on the same
  // edge that leaves DRAIN, hence the look-ahead value.
  always_comb begin
    mismatch = cmp_valid && (i_mem_data != cmp_exp);
    err_next = o_err_cnt;
    if (mismatch && (o_err_cnt != {ERR_W{1'b1}}))
      err_next = o_err_cnt + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      cmp_valid  <= 1'b0;
      cmp_addr   <= '0;
      cmp_exp    <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_pass     <= 1'b0;
      o_err_cnt  <= '0;
      o_err_addr <= '0;
    end else begin
      o_done    <= 1'b0;
      cmp_valid <= rd_phase;
      cmp_addr  <= cnt;
      cmp_exp   <= rd_exp;
      if (mismatch) begin
        o_err_cnt <= err_next;
        if (o_err_cnt == '0)
          o_err_addr <= cmp_addr;
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            state      <= WR0;
            cnt        <= '0;
            o_busy     <= 1'b1;
            o_pass     <= 1'b0;
            o_err_cnt  <= '0;
            o_err_addr <= '0;
            cmp_valid  <= 1'b0;
          end
        end
        WR0, RD0, WR1, RD1: begin
          cnt <= cnt + 1'b1;
          if (cnt == {AW{1'b1}}) begin
            case (state)
              WR0:     state <= RD0;
              RD0:     state <= WR1;
              WR1:     state <= RD1;
              default: state <= DRAIN;
            endcase
          end
        end
        DRAIN: begin
          state  <= DONE;
          o_busy <= 1'b0;
          o_done <= 1'b1;
          o_pass <= (err_next == '0);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spsram_bist.sv
module tb_spsram_bist;
  localparam int DW = 64;
  localparam int AW = 6;
  localparam int D  = 64;
  localparam int LAST = 4*D + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, start;

  // dut_a: 8-bit error counter, dut_b: 6-bit error counter
  logic          busy_a, done_a, pass_a, wen_a, cen_a, oen_a;
  logic [7:0]    ecnt_a;
  logic [AW-1:0] eaddr_a, addr_a;
  logic [DW-1:0] wdata_a, rdata_a;
  logic          busy_b, done_b, pass_b, wen_b, cen_b, oen_b;
  logic [5:0]    ecnt_b;
  logic [AW-1:0] eaddr_b, addr_b;
  logic [DW-1:0] wdata_b, rdata_b;

  spsram_bist #(.DW(DW), .AW(AW), .ERR_W(8)) dut_a (
    .i_clk(clk), .i_rstn(rstn), .i_start(start),
    .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
    .o_err_cnt(ecnt_a), .o_err_addr(eaddr_a),
    .o_mem_data(wdata_a), .o_mem_addr(addr_a), .o_mem_wen(wen_a),
    .o_mem_cen(cen_a), .o_mem_oen(oen_a), .i_mem_data(rdata_a));

  spsram_bist #(.DW(DW), .AW(AW), .ERR_W(6)) dut_b (
    .i_clk(clk), .i_rstn(rstn), .i_start(start),
    .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
    .o_err_cnt(ecnt_b), .o_err_addr(eaddr_b),
    .o_mem_data(wdata_b), .o_mem_addr(addr_b), .o_mem_wen(wen_b),
    .o_mem_cen(cen_b), .o_mem_oen(oen_b), .i_mem_data(rdata_b));

  // SRAM models with read-side fault injection
  int            fault_mode = 0;
  logic [DW-1:0] s0 [D];
  logic [DW-1:0] s1 [D];
  logic [DW-1:0] mem_a [D];
  logic [DW-1:0] mem_b [D];

  function automatic logic [DW-1:0] fault_rd(input int mode, input int a, input logic [DW-1:0] w);
    logic [DW-1:0] one;
    one = 64'd1;
    case (mode)
      1:       return (a == 5) ? (w & ~(one << 5)) : w;
      2:       return w & ~one;
      3:       return '0;
      4:       return (w & ~s0[a]) | s1[a];
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (cen_a && wen_a) mem_a[addr_a] <= wdata_a;
    if (cen_a && oen_a) rdata_a <= fault_rd(fault_mode, int'(addr_a), mem_a[addr_a]);
    if (cen_b && wen_b) mem_b[addr_b] <= wdata_b;
    if (cen_b && oen_b) rdata_b <= fault_rd(fault_mode, int'(addr_b), mem_b[addr_b]);
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] walk(input int a);
    logic [DW-1:0] one;
    one = 64'd1;
    return one << (a % DW);
  endfunction

  // Reference: replay the two passes at word level, counting mismatches.
  task automatic ref_model(input int mode, input int ew, output int cnt, output int first);
    logic [DW-1:0] w;
    int sat;
    sat = (1 << ew) - 1;
    cnt = 0;
    first = 0;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < D; a++) begin
        w = (p == 0) ? walk(a) : ~walk(a);
        if (fault_rd(mode, a, w) != w) begin
          if (cnt == 0) first = a;
          if (cnt < sat) cnt++;
        end
      end
  endtask

  // Expected port state in cycle k after the start edge.
  task automatic check_cmd(input int k);
    logic [10:0]   ctl;
    logic [DW-1:0] dat;
    int p, a;
    logic w;
    ctl = '0;
    dat = '0;
    if (k < 4*D) begin
      p = k / D;
      a = k % D;
      w = (p == 0) || (p == 2);
      ctl = {1'b1, 1'b0, 1'b1, w, ~w, 6'(a)};
      if (w) dat = (p == 0) ? walk(a) : ~walk(a);
    end else if (k == 4*D) begin
      ctl = {1'b1, 10'b0};
    end else if (k == 4*D + 1) begin
      ctl = {1'b0, 1'b1, 9'b0};
    end
    chk($sformatf("ctl_a@%0d", k), 64'({busy_a, done_a, cen_a, wen_a, oen_a, addr_a}), 64'(ctl));
    chk($sformatf("wdata_a@%0d", k), wdata_a, dat);
    chk($sformatf("ctl_b@%0d", k), 64'({busy_b, done_b, cen_b, wen_b, oen_b, addr_b}), 64'(ctl));
    chk($sformatf("wdata_b@%0d", k), wdata_b, dat);
  endtask

  task automatic run_test(input string tag, input int mode, input int e_cnt_a,
                          input int e_addr, input int e_cnt_b, input bit glitch);
    logic e_pass;
    e_pass = (e_cnt_a == 0);
    fault_mode = mode;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= LAST; k++) begin
      if (k > 0) @(negedge clk);
      start = glitch && ((k == 10) || (k == 4*D + 1));
      check_cmd(k);
      if (k == 0) begin
        chk({tag, " clr_cnt_a"}, 64'(ecnt_a), 64'd0);
        chk({tag, " clr_addr_a"}, 64'(eaddr_a), 64'd0);
        chk({tag, " clr_pass_a"}, 64'(pass_a), 64'd0);
        chk({tag, " clr_cnt_b"}, 64'(ecnt_b), 64'd0);
      end
      if (k == 4*D + 1) begin
        chk({tag, " err_cnt_a"}, 64'(ecnt_a), 64'(e_cnt_a));
        chk({tag, " err_addr_a"}, 64'(eaddr_a), 64'(e_addr));
        chk({tag, " pass_a"}, 64'(pass_a), 64'(e_pass));
        chk({tag, " err_cnt_b"}, 64'(ecnt_b), 64'(e_cnt_b));
        chk({tag, " err_addr_b"}, 64'(eaddr_b), 64'(e_addr));
        chk({tag, " pass_b"}, 64'(pass_b), 64'(e_pass));
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    string name;
    int    mode;
    int    cnt_a;
    int    eaddr;
    int    cnt_b;
    bit    glitch;
  } vec_t;

  vec_t vecs [5];

  task automatic check_idle_results(input string tag);
    chk({tag, " busy_a"}, 64'(busy_a), 64'd0);
    chk({tag, " done_a"}, 64'(done_a), 64'd0);
    chk({tag, " cen_a"}, 64'(cen_a), 64'd0);
    chk({tag, " results_a"}, 64'({pass_a, ecnt_a, eaddr_a}), 64'd0);
    chk({tag, " busy_b"}, 64'(busy_b), 64'd0);
    chk({tag, " cen_b"}, 64'(cen_b), 64'd0);
    chk({tag, " results_b"}, 64'({pass_b, ecnt_b, eaddr_b}), 64'd0);
  endtask

  initial begin
    int rc_a, rf_a, rc_b, rf_b;
    vecs[0] = '{"ideal",   0, 0,   0, 0,  1'b1};
    vecs[1] = '{"addr5b5", 1, 1,   5, 1,  1'b0};
    vecs[2] = '{"bit0",    2, 64,  0, 63, 1'b0};
    vecs[3] = '{"zero",    3, 128, 0, 63, 1'b0};
    vecs[4] = '{"rerun",   0, 0,   0, 0,  1'b0};

    for (int a = 0; a < D; a++) begin
      mem_a[a] = '0;
      mem_b[a] = '0;
      s0[a] = '0;
      s1[a] = '0;
    end
    rdata_a = '0;
    rdata_b = '0;
    rstn  = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_results("reset");
    chk("reset wdata_a", wdata_a, 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_test(vecs[i].name, vecs[i].mode, vecs[i].cnt_a, vecs[i].eaddr, vecs[i].cnt_b, vecs[i].glitch);

    // Random sparse stuck-at faults against the word-level reference.
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < D; a++) begin
        s0[a] = '0;
        s1[a] = '0;
        if ($urandom_range(0, 7) == 0) s0[a] = walk(int'($urandom_range(0, 63)));
        if ($urandom_range(0, 7) == 0) s1[a] = walk(int'($urandom_range(0, 63)));
      end
      ref_model(4, 8, rc_a, rf_a);
      ref_model(4, 6, rc_b, rf_b);
      run_test($sformatf("rand%0d", r), 4, rc_a, rf_a, rc_b, 1'b0);
    end

    // Reset during RD0 with a mismatch already counted.
    fault_mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 100; k++) @(negedge clk);
    chk("pre_rst err_cnt_a", 64'(ecnt_a), 64'd1);
    chk("pre_rst busy_a", 64'(busy_a), 64'd1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check_idle_results("post_rst");
    @(negedge clk);
    check_idle_results("post_rst+1");
    run_test("after_rst", 0, 0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
